pll_phase_responder: RTL and testbench
======================================

PLL_PHASE_RESPONDER -- requirements
Module: pll_phase_responder

Interface
REQ-001 Parameter DONE_EDGES, default 2: scanclk rising edges spent in BUSY before a step completes.
REQ-002 Parameter LOCK_CYCLES, default 16: clk cycles from areset deassertion to locked.
REQ-003 Port clk  in  1  sole clock; all state on rising edge.
REQ-004 Port rstn  in  1  asynchronous active-low reset.
REQ-005 Port areset  in  1  PLL reset request, active high.
REQ-006 Port clkswitch  in  1  clock-input switch request; rising edge toggles source.
REQ-007 Port scanclk  in  1  phase-shift strobe clock.
REQ-008 Port phasestep  in  1  step request, sampled on scanclk rise.
REQ-009 Port phasecounterselect  in  3  000 all, 001 M, 010 C0, 011 C1, 100 C2, 101 C3, 110 C4, 111 none.
REQ-010 Port phaseupdown  in  1  1 up, 0 down.
REQ-011 Port rd_sel  in  3  read-back select, same encoding as phasecounterselect.
REQ-012 Port phase_done  out  1  low while a step is in progress.
REQ-013 Port locked  out  1  emulated PLL lock.
REQ-014 Port clksrc  out  1  active input, 0 inclk0, 1 inclk1.
REQ-015 Port rd_phase  out  8  phase accumulator selected by rd_sel.
REQ-016 Port step_count  out  16  completed steps, saturating at 0xFFFF.

Function
REQ-017 areset, clkswitch, scanclk and phasestep SHALL each pass a two-flop synchronizer; all behaviour below uses the synchronized values.
REQ-018 A scanclk rise SHALL be detected as synchronized scanclk high with its previous value low.
REQ-019 The FSM SHALL have the states IDLE, ARMED, BUSY, RELEASE, and its transitions SHALL occur only on scanclk rises.
REQ-020 IDLE: on a rise with phasestep=1, the FSM SHALL latch phasecounterselect and phaseupdown and go to ARMED.
REQ-021 ARMED: on a rise with phasestep=1 the FSM SHALL go to BUSY with phase_done=0 and the edge counter cleared; with phasestep=0 it SHALL return to IDLE with no step applied.
REQ-022 BUSY: the FSM SHALL count rises. On the DONE_EDGES-th rise it SHALL apply the step, set phase_done=1 and increment step_count. It SHALL then go to IDLE if phasestep=0 at that rise, else to RELEASE.
REQ-023 RELEASE: the FSM SHALL go to IDLE on the first rise with phasestep=0, so each assertion yields exactly one step.
REQ-024 Step application: six 8-bit accumulators (M, C0..C4) SHALL change by +1 (up) or -1 (down), modulo 256 (255+1 gives 0, 0-1 gives 255). Select 000 updates all six; 111 updates none but still completes the handshake.
REQ-025 rd_phase SHALL be a combinational mux; for rd_sel 000 or 111 it SHALL be 0.
REQ-026 On a synchronized clkswitch rising edge, clksrc SHALL toggle, independent of FSM state.
REQ-027 While synchronized areset=1: accumulators SHALL clear to 0, the FSM SHALL go to IDLE (aborting any BUSY step with no update), phase_done=1, locked=0 and clksrc=0; step_count is unaffected.
REQ-028 locked SHALL rise exactly LOCK_CYCLES clk cycles after synchronized areset falls, and SHALL stay low if areset reasserts first.
REQ-029 If areset and a completing step coincide, areset SHALL win.

Reset
REQ-030 On rstn low: state IDLE, phase_done=1, locked=0, clksrc=0, accumulators 0, step_count 0, synchronizers 0, lock counter 0.
REQ-031 Release of rstn SHALL start the LOCK_CYCLES count as if areset had just fallen.

Structure
REQ-032 Package pll_dps_pkg SHALL hold the select encodings, the FSM state enum, and the DONE_EDGES and LOCK_CYCLES defaults.
REQ-033 Sub-module sync2 (two-flop synchronizer, async active-low reset) SHALL be instantiated once per asynchronous input.

Verification
REQ-034 Select 010, up, phasestep high for 3 scanclk rises: phase_done low for 2 rises, C0 goes 0 to 1, step_count=1, other accumulators 0.
REQ-035 Select 000, down, one step from reset: all six accumulators read 255.
REQ-036 phasestep high at only one rise: the FSM enters ARMED then returns to IDLE, with no change and step_count=0.
REQ-037 phasestep held high for 10 rises: exactly one step applied, and the FSM stays in RELEASE until phasestep drops.
REQ-038 areset pulsed during BUSY: no step applied, phase_done=1, accumulators 0; locked rises 16 clk after the synchronized areset falls.
REQ-039 Two clkswitch pulses followed by areset: clksrc goes 1, then 0, then stays 0 after areset.

Source files
------------

// File: rtl/pll_dps_pkg.sv
// Shared encodings and defaults for the dynamic phase-shift responder.
// Select codes 001..110 address the accumulators M, C0..C4 in order.
package pll_dps_pkg;

  localparam int DONE_EDGES_DEF  = 2;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int NUM_ACC         = 6;

  localparam logic [2:0] SEL_ALL  = 3'b000;
  localparam logic [2:0] SEL_M    = 3'b001;
  localparam logic [2:0] SEL_C0   = 3'b010;
  localparam logic [2:0] SEL_C1   = 3'b011;
  localparam logic [2:0] SEL_C2   = 3'b100;
  localparam logic [2:0] SEL_C3   = 3'b101;
  localparam logic [2:0] SEL_C4   = 3'b110;
  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } dps_state_e;

  // Accumulator idx answers to select code idx+1, or to the broadcast code.
  function automatic logic sel_hit(input logic [2:0] sel, input int idx);
    return (sel == SEL_ALL) || (sel == 3'(idx + 1));
  endfunction

endpackage

// File: rtl/pll_phase_responder_if.sv
// Phase-step request/response and read-back bundle of the phase responder.
interface pll_phase_responder_if;
  logic        phasestep;
  logic [2:0]  phasecounterselect;
  logic        phaseupdown;
  logic [2:0]  rd_sel;
  logic        phase_done;
  logic [7:0]  rd_phase;
  logic [15:0] step_count;

  modport master (
    output phasestep, phasecounterselect, phaseupdown, rd_sel,
    input  phase_done, rd_phase, step_count
  );

  modport slave (
    input  phasestep, phasecounterselect, phaseupdown, rd_sel,
    output phase_done, rd_phase, step_count
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic q_r;

  // Two-stage capture chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/pll_phase_responder.sv
// Emulates a PLL's dynamic phase-shift port: scanclk-strobed step handshake,
// six phase accumulators, clock-source switch and a lock timer.
module pll_phase_responder
  import pll_dps_pkg::*;
#(
  parameter int DONE_EDGES  = DONE_EDGES_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         areset,
  input  logic                         clkswitch,
  input  logic                         scanclk,
  pll_phase_responder_if.slave         dps,
  output logic                         locked,
  output logic                         clksrc
);

  localparam logic [7:0]  EDGE_LAST = 8'(DONE_EDGES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  logic areset_s, clkswitch_s, scanclk_s, phasestep_s;
  logic scan_prev_r, clksw_prev_r;
  logic scan_rise_s, clksw_rise_s;

  dps_state_e  state_r, state_nxt_s;
  logic [2:0]  sel_r;
  logic        up_r;
  logic [7:0]  edge_cnt_r;
  logic        last_edge_s;
  logic        latch_s, clr_cnt_s, inc_cnt_s, apply_s;
  logic [7:0]  acc_r [NUM_ACC];
  logic [15:0] step_count_r;
  logic        phase_done_r;
  logic        clksrc_r;
  logic        locked_r;
  logic [15:0] lock_cnt_r;
  logic [7:0]  rd_phase_s;

  sync2 u_sync_areset    (.clk(clk), .rstn(rstn), .d(areset),        .q(areset_s));
  sync2 u_sync_clkswitch (.clk(clk), .rstn(rstn), .d(clkswitch),     .q(clkswitch_s));
  sync2 u_sync_scanclk   (.clk(clk), .rstn(rstn), .d(scanclk),       .q(scanclk_s));
  sync2 u_sync_phasestep (.clk(clk), .rstn(rstn), .d(dps.phasestep), .q(phasestep_s));

  assign scan_rise_s  = scanclk_s & ~scan_prev_r;
  assign clksw_rise_s = clkswitch_s & ~clksw_prev_r;
  assign last_edge_s  = (edge_cnt_r == EDGE_LAST);

  // Previous-value registers for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_prev_r  <= 1'b0;
      clksw_prev_r <= 1'b0;
    end else begin
      scan_prev_r  <= scanclk_s;
      clksw_prev_r <= clkswitch_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; areset overrides any scanclk activity.
  always_comb begin
    state_nxt_s = state_r;
    if (areset_s) begin
      state_nxt_s = ST_IDLE;
    end else if (scan_rise_s) begin
      case (state_r)
        ST_IDLE:    state_nxt_s = phasestep_s ? ST_ARMED : ST_IDLE;
        ST_ARMED:   state_nxt_s = phasestep_s ? ST_BUSY : ST_IDLE;
        ST_BUSY: begin
          if (last_edge_s) begin
            state_nxt_s = phasestep_s ? ST_RELEASE : ST_IDLE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_RELEASE: state_nxt_s = phasestep_s ? ST_RELEASE : ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM action strobes, all qualified by a scanclk rise outside areset.
  always_comb begin
    latch_s   = 1'b0;
    clr_cnt_s = 1'b0;
    inc_cnt_s = 1'b0;
    apply_s   = 1'b0;
    if (!areset_s && scan_rise_s) begin
      case (state_r)
        ST_IDLE:  latch_s   = phasestep_s;
        ST_ARMED: clr_cnt_s = phasestep_s;
        ST_BUSY: begin
          if (last_edge_s) begin
            apply_s = 1'b1;
          end else begin
            inc_cnt_s = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      latch_s = 1'b0;
    end
  end

  // Captured step request and BUSY edge counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_r      <= SEL_NONE;
      up_r       <= 1'b0;
      edge_cnt_r <= 8'd0;
    end else begin
      if (latch_s) begin
        sel_r <= dps.phasecounterselect;
        up_r  <= dps.phaseupdown;
      end
      if (clr_cnt_s) begin
        edge_cnt_r <= 8'd0;
      end else if (inc_cnt_s) begin
        edge_cnt_r <= edge_cnt_r + 8'd1;
      end
    end
  end

  // Phase accumulators, wrapping modulo 256.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ACC; i++) acc_r[i] <= 8'd0;
    end else if (areset_s) begin
      for (int i = 0; i < NUM_ACC; i++) acc_r[i] <= 8'd0;
    end else if (apply_s) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (sel_hit(sel_r, i)) begin
          acc_r[i] <= up_r ? (acc_r[i] + 8'd1) : (acc_r[i] - 8'd1);
        end
      end
    end
  end

  // Completed-step counter (saturating) and done flag; areset leaves the count alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_count_r <= 16'd0;
      phase_done_r <= 1'b1;
    end else begin
      if (apply_s && (step_count_r != 16'hFFFF)) begin
        step_count_r <= step_count_r + 16'd1;
      end
      phase_done_r <= (state_nxt_s != ST_BUSY);
    end
  end

  // Input clock source toggle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clksrc_r <= 1'b0;
    end else if (areset_s) begin
      clksrc_r <= 1'b0;
    end else if (clksw_rise_s) begin
      clksrc_r <= ~clksrc_r;
    end
  end

  // Lock timer: counts from the end of areset (or rstn) up to LOCK_CYCLES.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else if (areset_s) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else if (!locked_r) begin
      if (lock_cnt_r == LOCK_LAST) begin
        locked_r <= 1'b1;
      end else begin
        lock_cnt_r <= lock_cnt_r + 16'd1;
      end
    end
  end

  // Read-back mux; broadcast and none codes read as zero.
  always_comb begin
    rd_phase_s = 8'd0;
    case (dps.rd_sel)
      SEL_M:   rd_phase_s = acc_r[0];
      SEL_C0:  rd_phase_s = acc_r[1];
      SEL_C1:  rd_phase_s = acc_r[2];
      SEL_C2:  rd_phase_s = acc_r[3];
      SEL_C3:  rd_phase_s = acc_r[4];
      SEL_C4:  rd_phase_s = acc_r[5];
      default: rd_phase_s = 8'd0;
    endcase
  end

  assign dps.rd_phase   = rd_phase_s;
  assign dps.step_count = step_count_r;
  assign dps.phase_done = phase_done_r;
  assign locked         = locked_r;
  assign clksrc         = clksrc_r;

endmodule

// File: tb/tb_pll_phase_responder.sv
// Directed bench for pll_phase_responder: step table plus hand-written
// abort, release, lock-timing and clock-switch sequences.
module tb_pll_phase_responder;
  import pll_dps_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic areset = 1'b0;
  logic clkswitch = 1'b0;
  logic scanclk = 1'b0;
  logic locked, clksrc;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  sel;
    logic        up;
    logic [2:0]  rd;
    logic [7:0]  exp_phase;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  pll_phase_responder_if dps_if ();

  pll_phase_responder #(.DONE_EDGES(2), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .areset(areset), .clkswitch(clkswitch),
    .scanclk(scanclk), .dps(dps_if), .locked(locked), .clksrc(clksrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_rise(input logic step);
    dps_if.phasestep = step;
    waitn(4);
    scanclk = 1'b1;
    waitn(4);
    scanclk = 1'b0;
    waitn(4);
  endtask

  task automatic do_step(input logic [2:0] sel, input logic up);
    dps_if.phasecounterselect = sel;
    dps_if.phaseupdown = up;
    scan_rise(1'b1);
    scan_rise(1'b1);
    scan_rise(1'b1);
    scan_rise(1'b0);
  endtask

  task automatic chk_acc(input string name, input logic [2:0] s, input logic [7:0] exp);
    dps_if.rd_sel = s;
    #1;
    chk(name, 32'(dps_if.rd_phase), 32'(exp));
  endtask

  task automatic pulse_switch();
    clkswitch = 1'b1;
    waitn(4);
    clkswitch = 1'b0;
    waitn(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // State carried over from the C0 step at the start of the test.
    vecs[0] = '{SEL_M,    1'b1, SEL_M,  8'd1,   16'd2};
    vecs[1] = '{SEL_ALL,  1'b0, SEL_C1, 8'd255, 16'd3};
    vecs[2] = '{SEL_NONE, 1'b1, SEL_C2, 8'd255, 16'd4};
    vecs[3] = '{SEL_C4,   1'b1, SEL_C4, 8'd0,   16'd5};
    vecs[4] = '{SEL_C0,   1'b0, SEL_C0, 8'd255, 16'd6};
    vecs[5] = '{SEL_C3,   1'b0, SEL_C3, 8'd254, 16'd7};
    vecs[6] = '{SEL_C2,   1'b1, SEL_C2, 8'd0,   16'd8};
    vecs[7] = '{SEL_M,    1'b0, SEL_M,  8'd255, 16'd9};

    dps_if.phasestep = 1'b0;
    dps_if.phasecounterselect = SEL_NONE;
    dps_if.phaseupdown = 1'b0;
    dps_if.rd_sel = SEL_ALL;

    waitn(3);
    chk("rst_done", 32'(dps_if.phase_done), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_clksrc", 32'(clksrc), 32'd0);
    chk("rst_count", 32'(dps_if.step_count), 32'd0);
    for (int s = 1; s <= 6; s++) chk_acc("rst_acc", 3'(s), 8'd0);

    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk("lock_after_rstn", 32'(locked), 32'(i >= 16));
    end

    // Single C0 up step: done low across the two BUSY rises.
    dps_if.phasecounterselect = SEL_C0;
    dps_if.phaseupdown = 1'b1;
    for (int k = 0; k < 4; k++) begin
      scan_rise(k < 3);
      chk("c0_done", 32'(dps_if.phase_done), 32'((k == 1 || k == 2) ? 0 : 1));
    end
    for (int s = 1; s <= 6; s++) chk_acc("c0_acc", 3'(s), (s == 2) ? 8'd1 : 8'd0);
    chk("c0_count", 32'(dps_if.step_count), 32'd1);

    for (int v = 0; v < 8; v++) begin
      do_step(vecs[v].sel, vecs[v].up);
      chk_acc("vec_phase", vecs[v].rd, vecs[v].exp_phase);
      chk("vec_count", 32'(dps_if.step_count), 32'(vecs[v].exp_cnt));
      chk("vec_done", 32'(dps_if.phase_done), 32'd1);
    end
    chk_acc("rd_all_zero", SEL_ALL, 8'd0);
    chk_acc("rd_none_zero", SEL_NONE, 8'd0);

    // One-rise request: ARMED then back to IDLE, nothing applied.
    dps_if.phasecounterselect = SEL_C1;
    dps_if.phaseupdown = 1'b1;
    scan_rise(1'b1);
    chk("short_done1", 32'(dps_if.phase_done), 32'd1);
    scan_rise(1'b0);
    chk("short_done2", 32'(dps_if.phase_done), 32'd1);
    scan_rise(1'b0);
    chk("short_count", 32'(dps_if.step_count), 32'd9);
    chk_acc("short_c1", SEL_C1, 8'd255);

    // Held request: exactly one step, then parked in RELEASE.
    for (int k = 1; k <= 10; k++) begin
      scan_rise(1'b1);
      chk("hold_done", 32'(dps_if.phase_done), 32'((k == 2 || k == 3) ? 0 : 1));
      chk("hold_count", 32'(dps_if.step_count), 32'((k >= 4) ? 10 : 9));
    end
    scan_rise(1'b0);
    chk("hold_done_end", 32'(dps_if.phase_done), 32'd1);
    chk_acc("hold_c1", SEL_C1, 8'd0);
    chk("hold_count_end", 32'(dps_if.step_count), 32'd10);

    // areset lands together with the completing rise of a BUSY step.
    dps_if.phasecounterselect = SEL_M;
    dps_if.phaseupdown = 1'b1;
    scan_rise(1'b1);
    scan_rise(1'b1);
    scan_rise(1'b1);
    chk("abort_busy", 32'(dps_if.phase_done), 32'd0);
    dps_if.phasestep = 1'b1;
    scanclk = 1'b1;
    areset = 1'b1;
    waitn(6);
    chk("abort_done", 32'(dps_if.phase_done), 32'd1);
    chk("abort_locked", 32'(locked), 32'd0);
    scanclk = 1'b0;
    dps_if.phasestep = 1'b0;
    waitn(4);
    areset = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk);
      #1;
      chk("lock_after_areset", 32'(locked), 32'(i >= 18));
    end
    waitn(2);
    chk("abort_count", 32'(dps_if.step_count), 32'd10);
    for (int s = 1; s <= 6; s++) chk_acc("abort_acc", 3'(s), 8'd0);

    // Clock source toggling and areset override.
    chk("sw_init", 32'(clksrc), 32'd0);
    pulse_switch();
    chk("sw_first", 32'(clksrc), 32'd1);
    pulse_switch();
    chk("sw_second", 32'(clksrc), 32'd0);
    pulse_switch();
    chk("sw_third", 32'(clksrc), 32'd1);
    areset = 1'b1;
    waitn(4);
    chk("sw_areset", 32'(clksrc), 32'd0);
    pulse_switch();
    chk("sw_during_areset", 32'(clksrc), 32'd0);
    areset = 1'b0;
    waitn(4);
    chk("sw_after_areset", 32'(clksrc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
